// File: rtl/ovl_fire_collector_if.sv
// Bundle between an OVL fire collector and its environment: fire inputs, control and the
// head-of-queue event stream with its status counters.
interface ovl_fire_collector_if #(
  parameter int unsigned N_CHK = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned CHK_W = (N_CHK > 1) ? $clog2(N_CHK) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic                 enable;
  logic                 clear;
  logic [3*N_CHK-1:0]   fire_in;
  logic                 evt_ready;
  logic                 evt_valid;
  logic [CHK_W-1:0]     evt_chk;
  logic [2:0]           evt_fire;
  logic [TS_W-1:0]      evt_ts;
  logic [LVL_W-1:0]     fifo_level;
  logic [CNT_W-1:0]     evt_cnt;
  logic [CNT_W-1:0]     drop_cnt;
  logic                 overflow;

  modport master (
    output enable, clear, fire_in, evt_ready,
    input  evt_valid, evt_chk, evt_fire, evt_ts, fifo_level, evt_cnt, drop_cnt, overflow
  );

  modport slave (
    input  enable, clear, fire_in, evt_ready,
    output evt_valid, evt_chk, evt_fire, evt_ts, fifo_level, evt_cnt, drop_cnt, overflow
  );
endinterface

// File: rtl/ovl_fire_collector.sv
// Collects OVL checker fire events into a timestamped FIFO, one winner per cycle (lowest index),
// counting accepted and lost events with saturating counters and a sticky overflow flag.
module ovl_fire_collector #(
  parameter int unsigned N_CHK = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16,
  parameter int unsigned CNT_W = 8
) (
  input logic                 clock,
  input logic                 reset,
  ovl_fire_collector_if.slave bus_io
);
  localparam int unsigned CHK_W = (N_CHK > 1) ? $clog2(N_CHK) : 1;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;
  localparam int unsigned NUM_W = $clog2(N_CHK + 1);
  localparam int unsigned SUM_W = CNT_W + NUM_W;

  logic [TS_W-1:0]  ts_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d, drop_cnt_q, drop_cnt_d;
  logic             ovf_q, ovf_d;

  logic [CHK_W-1:0] mem_chk  [DEPTH];
  logic [2:0]       mem_fire [DEPTH];
  logic [TS_W-1:0]  mem_ts   [DEPTH];

  logic [N_CHK-1:0] fire_act;
  logic             any_fire;
  logic [CHK_W-1:0] win_idx;
  logic [2:0]       win_fire;
  logic [NUM_W-1:0] fire_num, drop_inc;
  logic [SUM_W-1:0] drop_sum;
  logic             full, pop, push, valid;

  // Firing decode and lowest-index priority select.
  always_comb begin
    fire_act = '0;
    fire_num = '0;
    win_idx  = '0;
    win_fire = '0;
    for (int i = 0; i < N_CHK; i++) begin
      fire_act[i] = bus_io.enable && (bus_io.fire_in[3*i +: 3] != 3'b000);
      fire_num    = fire_num + NUM_W'(fire_act[i]);
    end
    for (int i = N_CHK - 1; i >= 0; i--) begin
      if (fire_act[i]) begin
        win_idx  = CHK_W'(i);
        win_fire = bus_io.fire_in[3*i +: 3];
      end
    end
    any_fire = |fire_act;
  end

  assign valid = (level_q != '0);
  assign full  = (level_q == LVL_W'(DEPTH));
  assign pop   = valid && bus_io.evt_ready;
  assign push  = any_fire && (!full || pop);
  // Every firing checker is lost except a winner that actually made it into the FIFO.
  assign drop_inc = fire_num - NUM_W'(push);
  assign drop_sum = SUM_W'(drop_cnt_q) + SUM_W'(drop_inc);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    evt_cnt_d  = evt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    if (bus_io.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      evt_cnt_d  = '0;
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
      if (push && (evt_cnt_q != {CNT_W{1'b1}})) begin
        evt_cnt_d = evt_cnt_q + CNT_W'(1);
      end
      if (drop_sum > SUM_W'({CNT_W{1'b1}})) begin
        drop_cnt_d = {CNT_W{1'b1}};
      end else begin
        drop_cnt_d = drop_sum[CNT_W-1:0];
      end
      if (drop_inc != '0) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      evt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ts_q       <= ts_q + TS_W'(1);
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      evt_cnt_q  <= evt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: pointers and level alone define which entries are live.
  always_ff @(posedge clock) begin
    if (push && !bus_io.clear) begin
      mem_chk[wr_ptr_q]  <= win_idx;
      mem_fire[wr_ptr_q] <= win_fire;
      mem_ts[wr_ptr_q]   <= ts_q;
    end
  end

  assign bus_io.evt_valid  = valid;
  assign bus_io.evt_chk    = valid ? mem_chk[rd_ptr_q]  : '0;
  assign bus_io.evt_fire   = valid ? mem_fire[rd_ptr_q] : '0;
  assign bus_io.evt_ts     = valid ? mem_ts[rd_ptr_q]   : '0;
  assign bus_io.fifo_level = level_q;
  assign bus_io.evt_cnt    = evt_cnt_q;
  assign bus_io.drop_cnt   = drop_cnt_q;
  assign bus_io.overflow   = ovf_q;
endmodule

// File: tb/tb_ovl_fire_collector.sv
// Directed bench for ovl_fire_collector: a default instance plus a TS_W=4 instance for wrap.
module tb_ovl_fire_collector;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  ovl_fire_collector_if #(.N_CHK(4), .DEPTH(8), .TS_W(16), .CNT_W(8)) bus ();
  ovl_fire_collector_if #(.N_CHK(4), .DEPTH(8), .TS_W(4), .CNT_W(8))  bus2 ();

  ovl_fire_collector #(.N_CHK(4), .DEPTH(8), .TS_W(16), .CNT_W(8)) u_dut (
    .clock  (clock),
    .reset  (reset),
    .bus_io (bus)
  );

  ovl_fire_collector #(.N_CHK(4), .DEPTH(8), .TS_W(4), .CNT_W(8)) u_dut_w (
    .clock  (clock),
    .reset  (reset),
    .bus_io (bus2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference timestamp: value held by the DUT counter between edges.
  logic [15:0] ts_m;
  always @(posedge clock or posedge reset) begin
    if (reset) ts_m <= '0;
    else       ts_m <= ts_m + 16'd1;
  end

  logic [1:0]  exp_chk  [9];
  logic [2:0]  exp_fire [9];
  logic [15:0] exp_ts   [9];

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic fire_one(input int c, input logic [2:0] p);
    bus.fire_in = 12'(p) << (3 * c);
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.evt_valid, bus.evt_chk, bus.evt_fire, bus.evt_ts} !== '0) begin
      errors++;
      $display("FAIL reset_head got %h exp 0", {bus.evt_valid, bus.evt_chk, bus.evt_fire, bus.evt_ts});
    end
    checks++;
    if ({bus.fifo_level, bus.evt_cnt, bus.drop_cnt, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL reset_status got %h exp 0", {bus.fifo_level, bus.evt_cnt, bus.drop_cnt, bus.overflow});
    end
    checks++;
    if ({bus2.evt_valid, bus2.evt_ts} !== '0) begin
      errors++;
      $display("FAIL reset_w_head got %h exp 0", {bus2.evt_valid, bus2.evt_ts});
    end
  endtask

  task automatic test_single_fire();
    logic [15:0] t;
    bus.enable = 1'b1;
    fire_one(2, 3'b001);
    t = ts_m;
    tick();
    bus.fire_in = '0;
    checks++;
    if ({bus.evt_valid, bus.evt_chk, bus.evt_fire} !== {1'b1, 2'd2, 3'b001}) begin
      errors++;
      $display("FAIL single_head got %b exp 1_10_001", {bus.evt_valid, bus.evt_chk, bus.evt_fire});
    end
    checks++;
    if (bus.evt_ts !== t) begin
      errors++;
      $display("FAIL single_ts got %0d exp %0d", bus.evt_ts, t);
    end
    checks++;
    if ({bus.evt_cnt, bus.fifo_level} !== {8'd1, 4'd1}) begin
      errors++;
      $display("FAIL single_cnt got cnt %0d lvl %0d exp 1 1", bus.evt_cnt, bus.fifo_level);
    end
    tick();
    checks++;
    if ({bus.evt_valid, bus.evt_chk, bus.evt_ts} !== {1'b1, 2'd2, t}) begin
      errors++;
      $display("FAIL hold_head got %h exp %h", {bus.evt_valid, bus.evt_chk, bus.evt_ts}, {1'b1, 2'd2, t});
    end
    bus.evt_ready = 1'b1;
    tick();
    checks++;
    if ({bus.evt_valid, bus.evt_chk, bus.evt_fire, bus.evt_ts, bus.fifo_level} !== '0) begin
      errors++;
      $display("FAIL pop_empty got %h exp 0", {bus.evt_valid, bus.evt_chk, bus.evt_fire, bus.evt_ts});
    end
    tick();
    bus.evt_ready = 1'b0;
    checks++;
    if ({bus.fifo_level, bus.evt_cnt} !== {4'd0, 8'd1}) begin
      errors++;
      $display("FAIL ready_empty got lvl %0d cnt %0d exp 0 1", bus.fifo_level, bus.evt_cnt);
    end
  endtask

  task automatic test_simultaneous();
    bus.fire_in = (12'(3'b100) << 3) | (12'(3'b010) << 9);
    tick();
    bus.fire_in = '0;
    checks++;
    if ({bus.evt_chk, bus.evt_fire} !== {2'd1, 3'b100}) begin
      errors++;
      $display("FAIL simul_head got %b exp 01_100", {bus.evt_chk, bus.evt_fire});
    end
    checks++;
    if ({bus.drop_cnt, bus.overflow, bus.evt_cnt} !== {8'd1, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL simul_cnt got drop %0d ovf %0d cnt %0d exp 1 1 2", bus.drop_cnt, bus.overflow,
               bus.evt_cnt);
    end
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
  endtask

  task automatic test_enable_clear();
    bus.enable = 1'b0;
    fire_one(0, 3'b111);
    tick();
    checks++;
    if ({bus.fifo_level, bus.evt_cnt} !== {4'd0, 8'd2}) begin
      errors++;
      $display("FAIL disabled got lvl %0d cnt %0d exp 0 2", bus.fifo_level, bus.evt_cnt);
    end
    bus.enable  = 1'b1;
    bus.fire_in = 12'b000_000_001_001;
    tick();
    checks++;
    if ({bus.fifo_level, bus.drop_cnt, bus.evt_cnt} !== {4'd1, 8'd2, 8'd3}) begin
      errors++;
      $display("FAIL pre_clear got lvl %0d drop %0d cnt %0d exp 1 2 3", bus.fifo_level,
               bus.drop_cnt, bus.evt_cnt);
    end
    bus.clear = 1'b1;
    tick();
    bus.clear   = 1'b0;
    bus.fire_in = '0;
    checks++;
    if ({bus.evt_valid, bus.fifo_level, bus.evt_cnt, bus.drop_cnt, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL clear got %h exp 0",
               {bus.evt_valid, bus.fifo_level, bus.evt_cnt, bus.drop_cnt, bus.overflow});
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 9; k++) begin
      exp_chk[k]  = 2'(k % 4);
      exp_fire[k] = 3'((k % 7) + 1);
      exp_ts[k]   = ts_m;
      fire_one(k % 4, exp_fire[k]);
      tick();
    end
    bus.fire_in = '0;
    checks++;
    if ({bus.fifo_level, bus.drop_cnt, bus.overflow, bus.evt_cnt} !== {4'd8, 8'd1, 1'b1, 8'd8}) begin
      errors++;
      $display("FAIL full got lvl %0d drop %0d ovf %0d cnt %0d exp 8 1 1 8", bus.fifo_level,
               bus.drop_cnt, bus.overflow, bus.evt_cnt);
    end
    bus.evt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({bus.evt_chk, bus.evt_fire, bus.evt_ts} !== {exp_chk[k], exp_fire[k], exp_ts[k]}) begin
        errors++;
        $display("FAIL drain_%0d got %h exp %h", k, {bus.evt_chk, bus.evt_fire, bus.evt_ts},
                 {exp_chk[k], exp_fire[k], exp_ts[k]});
      end
      tick();
    end
    bus.evt_ready = 1'b0;
    checks++;
    if ({bus.evt_valid, bus.fifo_level} !== '0) begin
      errors++;
      $display("FAIL drained got valid %0d lvl %0d exp 0 0", bus.evt_valid, bus.fifo_level);
    end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] t;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_chk[k] = 2'(k % 4);
      exp_ts[k]  = ts_m;
      fire_one(k % 4, 3'b001);
      tick();
    end
    fire_one(3, 3'b110);
    t = ts_m;
    bus.evt_ready = 1'b1;
    tick();
    bus.fire_in   = '0;
    bus.evt_ready = 1'b0;
    checks++;
    if ({bus.fifo_level, bus.drop_cnt, bus.overflow, bus.evt_cnt} !== {4'd8, 8'd0, 1'b0, 8'd9}) begin
      errors++;
      $display("FAIL push_pop got lvl %0d drop %0d ovf %0d cnt %0d exp 8 0 0 9", bus.fifo_level,
               bus.drop_cnt, bus.overflow, bus.evt_cnt);
    end
    checks++;
    if ({bus.evt_chk, bus.evt_ts} !== {exp_chk[1], exp_ts[1]}) begin
      errors++;
      $display("FAIL push_pop_head got %h exp %h", {bus.evt_chk, bus.evt_ts}, {exp_chk[1], exp_ts[1]});
    end
    bus.evt_ready = 1'b1;
    repeat (7) tick();
    bus.evt_ready = 1'b0;
    checks++;
    if ({bus.fifo_level, bus.evt_chk, bus.evt_fire, bus.evt_ts} !== {4'd1, 2'd3, 3'b110, t}) begin
      errors++;
      $display("FAIL wrap_tail got %h exp %h", {bus.fifo_level, bus.evt_chk, bus.evt_fire, bus.evt_ts},
               {4'd1, 2'd3, 3'b110, t});
    end
  endtask

  task automatic test_reset_wrap();
    fire_one(1, 3'b001);
    tick();
    tick();
    bus.fire_in = '0;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.evt_valid, bus.evt_chk, bus.evt_fire, bus.evt_ts, bus.fifo_level, bus.evt_cnt,
         bus.drop_cnt, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL async_reset got valid %0d lvl %0d cnt %0d", bus.evt_valid, bus.fifo_level,
               bus.evt_cnt);
    end
    tick();
    reset = 1'b0;
    fire_one(0, 3'b011);
    tick();
    bus.fire_in = '0;
    checks++;
    if ({bus.evt_valid, bus.evt_chk, bus.evt_fire, bus.evt_ts} !== {1'b1, 2'd0, 3'b011, 16'd0}) begin
      errors++;
      $display("FAIL resume got %h exp %h", {bus.evt_valid, bus.evt_chk, bus.evt_fire, bus.evt_ts},
               {1'b1, 2'd0, 3'b011, 16'd0});
    end
    repeat (15) tick();
    bus2.enable  = 1'b1;
    bus2.fire_in = 12'b001;
    tick();
    tick();
    bus2.fire_in = '0;
    checks++;
    if ({bus2.fifo_level, bus2.evt_ts} !== {4'd2, 4'd0}) begin
      errors++;
      $display("FAIL ts_wrap0 got lvl %0d ts %0d exp 2 0", bus2.fifo_level, bus2.evt_ts);
    end
    bus2.evt_ready = 1'b1;
    tick();
    bus2.evt_ready = 1'b0;
    checks++;
    if ({bus2.evt_valid, bus2.evt_ts} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL ts_wrap1 got valid %0d ts %0d exp 1 1", bus2.evt_valid, bus2.evt_ts);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.enable     = 1'b0;
    bus.clear      = 1'b0;
    bus.fire_in    = '0;
    bus.evt_ready  = 1'b0;
    bus2.enable    = 1'b0;
    bus2.clear     = 1'b0;
    bus2.fire_in   = '0;
    bus2.evt_ready = 1'b0;
    repeat (3) tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_single_fire();
    test_simultaneous();
    test_enable_clear();
    test_full();
    test_full_push_pop();
    test_reset_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ovl_fire_collector.md
OVL_FIRE_COLLECTOR -- requirements
Module: ovl_fire_collector

Interface
REQ-001 SHALL have parameter N_CHK, default 4: number of OVL checkers observed; legal range 1..16.
REQ-002 SHALL have parameter DEPTH, default 8: event FIFO depth; power of 2, minimum 2.
REQ-003 SHALL have parameter TS_W, default 16: timestamp width.
REQ-004 SHALL have parameter CNT_W, default 8: width of the event and drop counters.
REQ-005 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: when high, fire inputs are sampled.
REQ-008 SHALL have port clear, input, 1 bit: synchronous clear of FIFO, counters and sticky flag.
REQ-009 SHALL have port fire_in, input, 3*N_CHK bits: checker i occupies bits [3i+2:3i], in OVL fire encoding (bit0 assert, bit1 X-check, bit2 cover).
REQ-010 SHALL have port evt_ready, input, 1 bit: consumer accepts the head event.
REQ-011 SHALL have port evt_valid, output, 1 bit: a head event is present.
REQ-012 SHALL have port evt_chk, output, max(1,$clog2(N_CHK)) bits: checker index of the head event.
REQ-013 SHALL have port evt_fire, output, 3 bits: fire bits of the head event.
REQ-014 SHALL have port evt_ts, output, TS_W bits: timestamp of the head event.
REQ-015 SHALL have port fifo_level, output, $clog2(DEPTH)+1 bits: number of stored entries.
REQ-016 SHALL have port evt_cnt, output, CNT_W bits: count of accepted events, saturating.
REQ-017 SHALL have port drop_cnt, output, CNT_W bits: count of lost events, saturating.
REQ-018 SHALL have port overflow, output, 1 bit: sticky flag, set on any drop.

Function
REQ-019 SHALL run a free-running TS_W timestamp counter that increments every clock regardless of enable or clear and wraps from all-ones to 0.
REQ-020 SHALL treat checker i as firing in a cycle when enable=1 and fire_in[3i+2:3i] is not 000; fire_in SHALL be ignored when enable=0.
REQ-021 SHALL select one winner per cycle, the lowest-index firing checker, as the candidate entry {i, fire bits, current timestamp}.
REQ-022 SHALL count each firing checker other than the winner as dropped: drop_cnt increments by the number of losers, saturating, and overflow is set.
REQ-023 SHALL push the winner when the FIFO is not full, or when it is full and a pop occurs in the same cycle; otherwise the winner SHALL be dropped (drop_cnt +1, overflow set).
REQ-024 SHALL increment evt_cnt by 1, saturating at all-ones, for each pushed entry.
REQ-025 SHALL perform a pop when evt_valid=1 and evt_ready=1; evt_ready while empty SHALL have no effect.
REQ-026 SHALL assert evt_valid=1 whenever fifo_level is greater than 0, and SHALL hold evt_chk, evt_fire and evt_ts stable while evt_valid=1 and evt_ready=0.
REQ-027 SHALL have latency: fire sampled at edge t into an empty FIFO gives evt_valid=1 after edge t, so a push is visible in the following cycle; no combinational path from fire_in to outputs.
REQ-028 SHALL keep FIFO order first-in first-out; read and write pointers wrap modulo DEPTH.
REQ-029 SHALL, on clear=1, empty the FIFO, zero evt_cnt and drop_cnt, and clear overflow at the next edge; clear SHALL take priority over a same-cycle push, pop or drop.
REQ-030 SHALL drive evt_chk, evt_fire and evt_ts to 0 when evt_valid=0.

Reset
REQ-031 SHALL, on reset=1, asynchronously set timestamp=0, fifo_level=0, evt_valid=0, evt_chk=0, evt_fire=0, evt_ts=0, evt_cnt=0, drop_cnt=0 and overflow=0.
REQ-032 SHALL discard stored entries when reset is asserted mid-operation, and SHALL resume sampling fire_in at the first rising edge after reset is deasserted.

Verification
REQ-033 Single fire: checker 2 drives fire 001 for 1 cycle into an empty FIFO -> next cycle evt_valid=1, evt_chk=2, evt_fire=001, evt_ts equals the timestamp at the sampling edge; evt_cnt=1.
REQ-034 Simultaneous fire: checkers 1 and 3 fire in the same cycle -> the entry holds chk=1, drop_cnt=1, overflow=1.
REQ-035 Full FIFO: 9 single fires with evt_ready=0 and DEPTH=8 -> fifo_level=8, drop_cnt=1; then evt_ready=1 for 8 cycles -> entries come out in order and evt_valid goes to 0.
REQ-036 Full with push and pop in the same cycle: full FIFO, evt_ready=1 and a new fire -> fifo_level stays 8, no drop.
REQ-037 Enable and clear: fire with enable=0 -> no entry; clear in the same cycle as a fire -> fifo_level=0, all counters 0, overflow=0.
REQ-038 Reset and wrap: reset pulsed mid-stream -> all outputs 0 at once; with TS_W=4, 17 cycles after reset -> timestamp wrapped to 0 and then 1.
